ram_write_arbiter: RTL and testbench

Shares the single write port of the dual-read-port data RAM between two requesters: the MiniAlu execute stage (core) and a host loader that preloads or patches data memory while the program runs. Each requester uses a valid/ready handshake. The core has fixed priority, and a starvation counter promotes the host after a bounded wait. The granted write is registered onto the RAM write port, and per-requester write counters are kept for debug on the LED/status path.

---
 rtl/ram_write_arbiter.sv | 102 ++++++++++
 tb/tb_ram_write_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ram_write_arbiter.sv
// ram_write_arbiter
//
// Arbitrates the single write port of the data RAM between the MiniAlu
// execute stage (core) and a host loader. The core has fixed priority. A
// saturating wait counter promotes the host once it has been blocked for
// MAX_WAIT consecutive cycles. The granted write is registered onto the RAM
// write port. Per-requester transfer counters feed the debug/status path.
//
// Ports:
//   Clock, Reset                        clock; asynchronous active-low reset
//   iCoreValid/iCoreAddr/iCoreData      core write request
//   oCoreReady                          core granted this cycle (combinational)
//   iHostValid/iHostAddr/iHostData      host write request
//   oHostReady                          host granted this cycle (combinational)
//   oWriteEnable/oWriteAddress/oDataIn  registered RAM write port
//   oHostPriority                       host promoted (wait counter == MAX_WAIT)
//   oCoreWrites/oHostWrites             16-bit wrapping transfer counters
module ram_write_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WAIT   = 3
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iCoreValid,
  input  logic [ADDR_WIDTH-1:0] iCoreAddr,
  input  logic [DATA_WIDTH-1:0] iCoreData,
  output logic                  oCoreReady,
  input  logic                  iHostValid,
  input  logic [ADDR_WIDTH-1:0] iHostAddr,
  input  logic [DATA_WIDTH-1:0] iHostData,
  output logic                  oHostReady,
  output logic                  oWriteEnable,
  output logic [ADDR_WIDTH-1:0] oWriteAddress,
  output logic [DATA_WIDTH-1:0] oDataIn,
  output logic                  oHostPriority,
  output logic [15:0]           oCoreWrites,
  output logic [15:0]           oHostWrites
);

  localparam logic [3:0] WaitLimit = 4'(MAX_WAIT);

  logic [3:0] waitCount;
  logic       grantHost;
  logic       grantCore;

  // The host wins when the core is idle or when it has been promoted; the
  // two grants are mutually exclusive by construction.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    oHostPriority = (waitCount == WaitLimit);
    grantHost     = iHostValid & (~iCoreValid | oHostPriority);
    grantCore     = iCoreValid & ~grantHost;
    oCoreReady    = grantCore;
    oHostReady    = grantHost;
  end

  // Wait counter: counts consecutive cycles in which the host is valid but
  // not granted, saturating at the promotion threshold.
  always_ff @(posedge Clock or negedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!Reset) begin
      waitCount <= '0;
    end else if (!iHostValid || grantHost) begin
      waitCount <= '0;
    end else if (waitCount != WaitLimit) begin
      waitCount <= waitCount + 4'd1;
    end
  end

  // Registered write port. Address and data hold between writes so the RAM
  // side sees stable values; only the enable pulses.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      oWriteEnable  <= 1'b0;
      oWriteAddress <= '0;
      oDataIn       <= '0;
    end else if (grantHost) begin
      oWriteEnable  <= 1'b1;
      oWriteAddress <= iHostAddr;
      oDataIn       <= iHostData;
    end else if (grantCore) begin
      oWriteEnable  <= 1'b1;
      oWriteAddress <= iCoreAddr;
      oDataIn       <= iCoreData;
    end else begin
      oWriteEnable  <= 1'b0;
    end
  end

  // Debug transfer counters; 16-bit modulo wrap is intentional.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      oCoreWrites <= '0;
      oHostWrites <= '0;
    end else begin
      if (grantCore) oCoreWrites <= oCoreWrites + 16'd1;
      if (grantHost) oHostWrites <= oHostWrites + 16'd1;
    end
  end

endmodule

// File: tb/tb_ram_write_arbiter.sv
module tb_ram_write_arbiter;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int MAX_WAIT = 3;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          iCoreValid = 1'b0;
  logic [AW-1:0] iCoreAddr = '0;
  logic [DW-1:0] iCoreData = '0;
  logic          oCoreReady;
  logic          iHostValid = 1'b0;
  logic [AW-1:0] iHostAddr = '0;
  logic [DW-1:0] iHostData = '0;
  logic          oHostReady;
  logic          oWriteEnable;
  logic [AW-1:0] oWriteAddress;
  logic [DW-1:0] oDataIn;
  logic          oHostPriority;
  logic [15:0]   oCoreWrites;
  logic [15:0]   oHostWrites;

  ram_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WAIT(MAX_WAIT)) dut (
    .Clock(Clock), .Reset(Reset),
    .iCoreValid(iCoreValid), .iCoreAddr(iCoreAddr), .iCoreData(iCoreData), .oCoreReady(oCoreReady),
    .iHostValid(iHostValid), .iHostAddr(iHostAddr), .iHostData(iHostData), .oHostReady(oHostReady),
    .oWriteEnable(oWriteEnable), .oWriteAddress(oWriteAddress), .oDataIn(oDataIn),
    .oHostPriority(oHostPriority), .oCoreWrites(oCoreWrites), .oHostWrites(oHostWrites)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } write_t;

  write_t        expQ[$];
  int            checks = 0;
  int            errors = 0;
  int            waitModel = 0;
  logic [15:0]   coreModel = '0;
  logic [15:0]   hostModel = '0;
  logic [AW-1:0] lastAddr = '0;
  logic [DW-1:0] lastData = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive requests, check the grant against the bench's own
  // arbitration model, then check the registered write port after the edge.
  task automatic step(input logic cv, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                      input logic hv, input logic [AW-1:0] ha, input logic [DW-1:0] hd);
    logic expPri, expHost, expCore;
    write_t w;
    @(negedge Clock);
    iCoreValid = cv; iCoreAddr = ca; iCoreData = cd;
    iHostValid = hv; iHostAddr = ha; iHostData = hd;
    #1;
    expPri  = (waitModel == MAX_WAIT);
    expHost = hv & (!cv | expPri);
    expCore = cv & !expHost;
    check("coreReady", 32'(oCoreReady), 32'(expCore));
    check("hostReady", 32'(oHostReady), 32'(expHost));
    check("hostPriority", 32'(oHostPriority), 32'(expPri));
    if (expHost) begin
      w.addr = ha; w.data = hd; expQ.push_back(w); hostModel++;
    end else if (expCore) begin
      w.addr = ca; w.data = cd; expQ.push_back(w); coreModel++;
    end
    if (!hv || expHost) waitModel = 0;
    else if (waitModel < MAX_WAIT) waitModel++;
    @(posedge Clock);
    #1;
    if (expQ.size() > 0) begin
      w = expQ.pop_front();
      lastAddr = w.addr; lastData = w.data;
      check("writeEnable", 32'(oWriteEnable), 32'd1);
    end else begin
      check("writeEnable", 32'(oWriteEnable), 32'd0);
    end
    check("writeAddress", 32'(oWriteAddress), 32'(lastAddr));
    check("dataIn", 32'(oDataIn), 32'(lastData));
    check("coreWrites", 32'(oCoreWrites), 32'(coreModel));
    check("hostWrites", 32'(oHostWrites), 32'(hostModel));
  endtask

  task automatic checkResetState(input string tag);
    check({tag, "_we"}, 32'(oWriteEnable), 32'd0);
    check({tag, "_addr"}, 32'(oWriteAddress), 32'd0);
    check({tag, "_data"}, 32'(oDataIn), 32'd0);
    check({tag, "_pri"}, 32'(oHostPriority), 32'd0);
    check({tag, "_coreWrites"}, 32'(oCoreWrites), 32'd0);
    check({tag, "_hostWrites"}, 32'(oHostWrites), 32'd0);
  endtask

  initial begin
    // Reset values at start.
    #1;
    checkResetState("rst0");
    @(negedge Clock);
    Reset = 1'b1;

    // Core priority: four back-to-back core writes, host idle.
    for (int i = 0; i < 4; i++)
      step(1'b1, AW'(8'h10 + i), DW'(16'hA000 + i), 1'b0, '0, '0);
    check("coreWritesAfter4", 32'(oCoreWrites), 32'd4);

    // Hold stability: core drops valid, enable falls, addr/data hold.
    step(1'b0, '0, '0, 1'b0, '0, '0);
    check("holdAddr", 32'(oWriteAddress), 32'h13);
    check("holdData", 32'(oDataIn), 32'hA003);

    // Starvation: continuous core traffic with a waiting host.
    for (int i = 0; i < 6; i++)
      step(1'b1, AW'(8'h20 + i), DW'(16'hB000 + i), 1'b1, 8'h80, 16'h1234);
    // The host transferred at the 4th step; it now drops valid.
    step(1'b1, 8'h30, 16'hC000, 1'b0, '0, '0);
    check("hostWritesAfterStarve", 32'(oHostWrites), 32'd1);

    // Idle host: granted immediately, no wait build-up.
    step(1'b0, '0, '0, 1'b1, 8'h81, 16'h5678);
    step(1'b0, '0, '0, 1'b1, 8'h82, 16'h9ABC);
    step(1'b0, '0, '0, 1'b0, '0, '0);

    // Asynchronous reset mid-stream with both requesters valid.
    @(negedge Clock);
    iCoreValid = 1'b1; iCoreAddr = 8'h44; iCoreData = 16'hDEAD;
    iHostValid = 1'b1; iHostAddr = 8'h90; iHostData = 16'hBEEF;
    #2;
    Reset = 1'b0;
    #1;
    checkResetState("rstMid");
    check("rstMid_coreReady", 32'(oCoreReady), 32'd1);
    check("rstMid_hostReady", 32'(oHostReady), 32'd0);
    @(posedge Clock);
    #1;
    checkResetState("rstEdge");
    @(negedge Clock);
    Reset = 1'b1;
    iCoreValid = 1'b0; iHostValid = 1'b0;
    waitModel = 0; coreModel = '0; hostModel = '0;
    lastAddr = '0; lastData = '0;
    expQ.delete();

    // Counters restart from 0 after release.
    step(1'b1, 8'h01, 16'h0101, 1'b0, '0, '0);

    // Counter wrap: 65536 more core transfers bring the total to 65537.
    @(negedge Clock);
    iCoreValid = 1'b1; iCoreAddr = 8'h55; iCoreData = 16'hBEEF;
    repeat (65536) @(posedge Clock);
    #1;
    check("wrapCoreWrites", 32'(oCoreWrites), 32'd1);
    check("wrapWe", 32'(oWriteEnable), 32'd1);
    coreModel = 16'd1; lastAddr = 8'h55; lastData = 16'hBEEF;
    step(1'b0, '0, '0, 1'b0, '0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
